// File: rtl/multi_edge_pulse.sv
// multi_edge_pulse: per-channel synchroniser, selectable edge detector and
// retriggerable pulse stretcher with sticky overlap flags.
module multi_edge_pulse #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_W     = 1,
  parameter int unsigned CNT_W       = $clog2(PULSE_W + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_data,
  input  logic [1:0]      i_mode,
  input  logic            i_clr,
  output logic [N_CH-1:0] o_pulse,
  output logic [N_CH-1:0] o_ovl,
  output logic            o_any
);

  typedef enum logic [1:0] {
    ModeRise = 2'b00,
    ModeFall = 2'b01,
    ModeBoth = 2'b10,
    ModeOff  = 2'b11
  } mode_e;

  // Counter state is implied by the count itself: zero means idle.
  typedef enum logic {
    StIdle,
    StActive
  } cnt_st_e;

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(PULSE_W);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  sync_d [SYNC_STAGES];
  logic [N_CH-1:0]  prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [N_CH-1:0]  pulse_q, pulse_d;
  logic [N_CH-1:0]  ovl_q, ovl_d;
  logic             any_q, any_d;

  logic [N_CH-1:0]  sync_s;
  logic [N_CH-1:0]  rise, fall, edge_q;

  // Synchroniser shift and history capture.
  always_comb begin
    sync_d[0] = i_data;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_s = sync_q[SYNC_STAGES-1];
    prev_d = sync_s;
  end

  // Edge qualification; the mode applies to the edge evaluated this cycle.
  always_comb begin
    rise   = sync_s & ~prev_q;
    fall   = ~sync_s & prev_q;
    edge_q = '0;
    unique case (mode_e'(i_mode))
      ModeRise: edge_q = rise;
      ModeFall: edge_q = fall;
      ModeBoth: edge_q = rise | fall;
      ModeOff:  edge_q = '0;
    endcase
  end

  // Per-channel counter FSM, overlap flag and pulse next-state.
  always_comb begin
    cnt_st_e st;
    st      = StIdle;
    pulse_d = '0;
    ovl_d   = ovl_q;
    for (int ch = 0; ch < int'(N_CH); ch++) begin
      cnt_d[ch] = cnt_q[ch];
      st = (cnt_q[ch] == '0) ? StIdle : StActive;
      if (i_clr) ovl_d[ch] = 1'b0;
      unique case (st)
        StIdle: begin
          if (edge_q[ch]) cnt_d[ch] = CntLoad;
        end
        StActive: begin
          if (edge_q[ch]) begin
            // Retrigger: extend the pulse; a set beats a same-cycle clear.
            cnt_d[ch] = CntLoad;
            ovl_d[ch] = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] - 1'b1;
          end
        end
      endcase
      pulse_d[ch] = (cnt_d[ch] != '0);
    end
    any_d = |pulse_d;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      for (int ch = 0; ch < int'(N_CH); ch++) cnt_q[ch] <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      ovl_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_d[i];
      for (int ch = 0; ch < int'(N_CH); ch++) cnt_q[ch] <= cnt_d[ch];
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      ovl_q   <= ovl_d;
      any_q   <= any_d;
    end
  end

  assign o_pulse = pulse_q;
  assign o_ovl   = ovl_q;
  assign o_any   = any_q;

endmodule

// File: tb/tb_multi_edge_pulse.sv
// Bench for multi_edge_pulse: two instances (different sync depth and pulse
// width) share stimulus and are checked every cycle against a window model.
module tb_multi_edge_pulse;

  localparam int NCH = 4;
  localparam int SA  = 2;
  localparam int WA  = 3;
  localparam int SB  = 3;
  localparam int WB  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data = '0;
  logic [1:0] mode = '0;
  logic       clr = 1'b0;
  logic [3:0] pa, oa, pb, ob;
  logic       anya, anyb;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  multi_edge_pulse #(.N_CH(NCH), .SYNC_STAGES(SA), .PULSE_W(WA)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_mode(mode), .i_clr(clr),
    .o_pulse(pa), .o_ovl(oa), .o_any(anya)
  );

  multi_edge_pulse #(.N_CH(NCH), .SYNC_STAGES(SB), .PULSE_W(WB)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_mode(mode), .i_clr(clr),
    .o_pulse(pb), .o_ovl(ob), .o_any(anyb)
  );

  // ---------------- reference model ----------------
  // hist[j] is the input sampled at the j-th clock edge since reset. An edge
  // evaluated at edge n compares samples n-S and n-S-1. A trigger at edge n
  // keeps the pulse high after edges n .. n+W-1.
  logic [3:0] hist[$];
  int         n;
  int         last_trig[2][4];
  logic [3:0] m_pulse[2];
  logic [3:0] m_ovl[2];
  logic       m_any[2];

  function automatic logic [3:0] dget(int j);
    if (j < 0 || j >= hist.size()) return 4'b0;
    return hist[j];
  endfunction

  task automatic model_clear();
    hist.delete();
    n = 0;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 4; ch++) last_trig[d][ch] = -1000;
      m_pulse[d] = '0;
      m_ovl[d]   = '0;
      m_any[d]   = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int s, w;
      logic [3:0] cur, prv, tr;
      s   = (d == 0) ? SA : SB;
      w   = (d == 0) ? WA : WB;
      cur = dget(n - s);
      prv = dget(n - s - 1);
      case (mode)
        2'b00:   tr = cur & ~prv;
        2'b01:   tr = ~cur & prv;
        2'b10:   tr = cur ^ prv;
        default: tr = 4'b0;
      endcase
      for (int ch = 0; ch < 4; ch++) begin
        bit act;
        act = last_trig[d][ch] > n - 1 - w;
        if (tr[ch] && act) m_ovl[d][ch] = 1'b1;
        else if (clr)      m_ovl[d][ch] = 1'b0;
        if (tr[ch]) last_trig[d][ch] = n;
        m_pulse[d][ch] = last_trig[d][ch] > n - w;
      end
      m_any[d] = |m_pulse[d];
    end
    hist.push_back(data);
    n++;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else     model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("pulse_a", 32'(pa), 32'(m_pulse[0]));
        chk("ovl_a",   32'(oa), 32'(m_ovl[0]));
        chk("any_a",   32'(anya), 32'(m_any[0]));
        chk("pulse_b", 32'(pb), 32'(m_pulse[1]));
        chk("ovl_b",   32'(ob), 32'(m_ovl[1]));
        chk("any_b",   32'(anyb), 32'(m_any[1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    data = '0;
    clr  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [19:0] mode_exp [4] = '{20'h0001C, 20'h07000, 20'h0701C, 20'h00000};
  logic [31:0] rec_a, rec_b, rec_c, rec_d, rec_e;

  initial begin
    do_reset();
    chk_on = 1'b1;
    repeat (3) step();
    chk("reset_state", 32'({pa, oa, anya, pb, ob, anyb}), 32'h0);

    // Rise at E0, fall at E10 on ch0 under every mode.
    for (int m = 0; m < 4; m++) begin
      do_reset();
      mode  = 2'(m);
      rec_a = '0;
      for (int k = 0; k < 20; k++) begin
        data[0] = (k < 10);
        step();
        rec_a[k] = pa[0];
      end
      chk("mode_window", rec_a, 32'(mode_exp[m]));
    end

    // Retrigger, clear, and clear colliding with a new overlap on ch1.
    do_reset();
    mode  = 2'b10;
    rec_a = '0;
    rec_b = '0;
    for (int k = 0; k < 28; k++) begin
      data[1] = (k < 2) || (k == 20);
      clr     = (k == 10) || (k == 23);
      step();
      rec_a[k] = pa[1];
      rec_b[k] = oa[1];
    end
    clr = 1'b0;
    chk("retrig_pulse", rec_a, 32'h03C0007C);
    chk("retrig_ovl",   rec_b, 32'h0F8003F0);

    // All channels rise together.
    do_reset();
    mode  = 2'b00;
    rec_a = '0; rec_b = '0; rec_c = '0; rec_d = '0; rec_e = '0;
    for (int k = 0; k < 8; k++) begin
      data = 4'hF;
      step();
      rec_a[k] = (pa == 4'hF);
      rec_b[k] = anya;
      rec_c[k] = (pb == 4'hF);
      rec_d[k] = anyb;
      rec_e[k] = (pb == 4'h0);
    end
    chk("simul_all_a", rec_a, 32'h1C);
    chk("simul_any_a", rec_b, 32'h1C);
    chk("simul_all_b", rec_c, 32'h08);
    chk("simul_any_b", rec_d, 32'h08);
    chk("simul_zero_b", rec_e, 32'hF7);

    // Reset mid-pulse with ch0 held high; a fresh pulse follows release.
    do_reset();
    mode = 2'b00;
    data = 4'b0001;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_reset_pulse", 32'(pa[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_reset_out", 32'({pa, oa, anya, pb, ob, anyb}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    rec_a = '0;
    rec_b = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      rec_a[k] = pa[0];
      rec_b[k] = pb[0];
    end
    chk("post_reset_a", rec_a, 32'h01C);
    chk("post_reset_b", rec_b, 32'h008);

    // Toggling every cycle on ch3: both-edges then rising-only.
    for (int t = 0; t < 2; t++) begin
      do_reset();
      mode  = (t == 0) ? 2'b10 : 2'b00;
      rec_a = '0;
      rec_b = '0;
      for (int k = 0; k < 16; k++) begin
        if (k < 10) data[3] = ~k[0];
        step();
        rec_a[k] = pb[3];
        rec_b[k] = ob[3];
      end
      chk("toggle_pulse_b", rec_a, (t == 0) ? 32'h1FF8 : 32'h0AA8);
      chk("toggle_ovl_b",   rec_b, (t == 0) ? 32'hFFF0 : 32'h0000);
    end

    // Disable mid-pulse: pulse completes, later edges are ignored.
    do_reset();
    rec_a = '0;
    for (int k = 0; k < 16; k++) begin
      data[2] = !((k == 6) || (k == 7));
      mode    = (k >= 3) ? 2'b11 : 2'b00;
      step();
      rec_a[k] = pa[2];
    end
    chk("mode_off_mid", rec_a, 32'h001C);

    // Randomised traffic with occasional asynchronous resets.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(0, 3) == 0) data[ch] = ~data[ch];
      end
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_edge_pulse.md
# multi_edge_pulse

Parametrised, multi-channel successor to the single-bit level-to-pulse converter. Each of `N_CH` asynchronous level inputs is synchronised into the `i_clk` domain. A selectable edge type (rising, falling, both, or disabled) is detected, and a pulse of programmable width `PULSE_W` cycles is emitted per channel. Pulses retrigger on new edges, and overlaps are reported through sticky flags. The block sits between raw external/button/strobe levels and the control FSMs that consume single-cycle or stretched event pulses.

## Interface
Parameters:
- `N_CH`, default 4: number of independent channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser depth per channel (≥2).
- `PULSE_W`, default 1: output pulse width in `i_clk` cycles (≥1).
- `CNT_W`, default `$clog2(PULSE_W+1)`: width of the per-channel pulse counter.

Ports:
- `i_clk`, input, 1: the only clock; all logic on its rising edge.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_data`, input, `N_CH`: asynchronous level inputs, one bit per channel.
- `i_mode`, input, 2: edge select shared by all channels: 00 rising, 01 falling, 10 both, 11 disabled.
- `i_clr`, input, 1: synchronous clear of `o_ovl`.
- `o_pulse`, output, `N_CH`: per-channel registered pulse.
- `o_ovl`, output, `N_CH`: per-channel sticky overlap/retrigger flag.
- `o_any`, output, 1: registered OR of the next-state `o_pulse` bits, so it is cycle-aligned with `o_pulse`.

## Operation
- **Per-channel pipeline:**
  - Synchroniser chain `sync[0..SYNC_STAGES-1]`.
  - History flop `prev`, which holds the previous value of `sync[SYNC_STAGES-1]`.
  - Counter `cnt` (`CNT_W` bits).
- **Edge qualification.** Let `s = sync[SYNC_STAGES-1]`.
  - rise = `s & ~prev`
  - fall = `~s & prev`
  - `edge_q` = rise (mode 00), fall (01), rise|fall (10), 0 (11).
- **Counter FSM**, per channel:
  - IDLE (`cnt==0`): on `edge_q`, load `cnt = PULSE_W` and move to ACTIVE.
  - ACTIVE (`cnt>0`): decrement each cycle and return to IDLE at 0.
  - ACTIVE with `edge_q`: reload `cnt = PULSE_W` (retrigger, which extends the pulse) and set `o_ovl`.
- `o_pulse[i]` is a flop loaded with `(next cnt != 0)`. It is therefore high for exactly `PULSE_W` cycles per isolated edge and is glitch-free.
- **Mode changes** take effect for edges evaluated in the next cycle. Active pulses are never truncated. Mode 11 blocks new pulses only; running pulses complete.
- **`o_ovl` handling:**
  - Set on retrigger; cleared by `i_clr`.
  - If a set and `i_clr` occur in the same cycle, set wins.
- **Reset:** all flops (`sync`, `prev`, `cnt`, `o_pulse`, `o_ovl`, `o_any`) go to 0 asynchronously.
  - Consequence: an input held at 1 through reset release produces one rising edge once it propagates. This is required behaviour, not a bug.
- **Reset mid-pulse:** the pulse aborts immediately with no resumption.
- **Channel independence:** channels are fully independent; simultaneous edges on all channels each produce their own pulse.

## Timing
- Let edge E0 be the first `i_clk` edge that samples a new `i_data` value (setup met). Then:
  - `sync[SYNC_STAGES-1]` updates at E(`SYNC_STAGES-1`).
  - `o_pulse` rises at E(`SYNC_STAGES`), i.e. default latency is 2 cycles.
- `o_pulse` stays high through E(`SYNC_STAGES+PULSE_W-1`) and falls at E(`SYNC_STAGES+PULSE_W`).
- `o_ovl` asserts on the same edge as the retriggered `cnt` reload.
- Input pulses shorter than one `i_clk` period may be missed. This is not detected.
- `PULSE_W=1`, mode 10, input toggling every cycle: `o_pulse` is continuously high and `o_ovl` is set from the second edge onward.
- `PULSE_W=1`, mode 00, input toggling every cycle: a pulse appears every other cycle, with no overlap.
- The `cnt` decrement never underflows: it saturates at 0.

## Test plan
- **Reset state:** assert `i_rst` asynchronously mid-cycle with all `i_data=0` → all outputs 0 immediately, and they stay 0 after release.
- **Basic rise/fall per mode** (N_CH=4, SYNC_STAGES=2, PULSE_W=3):
  - Stimulus: ch0 0→1 at E0, back to 0 at E10.
  - Mode 00 → `o_pulse[0]` high E2–E4 only.
  - Mode 01 → high E12–E14 only.
  - Mode 10 → both windows.
  - Mode 11 → never.
- **Retrigger** (PULSE_W=4, mode 10): ch1 toggles at E0 and E2 → `o_pulse[1]` high E2–E7 continuously, and `o_ovl[1]` set at E4. Then:
  - `i_clr` at E9 → `o_ovl[1]` 0 at E10.
  - `i_clr` coinciding with a new overlap → `o_ovl` stays 1.
- **Simultaneous channels:** all 4 inputs rise at E0 (mode 00, PULSE_W=1) → `o_pulse=4'b1111` for exactly one cycle at E2, and `o_any=1` at E2 only.
- **Reset mid-pulse and held-high input:** PULSE_W=5, pulse active, `i_rst` pulsed at E3 with `i_data[0]=1` held → outputs 0 during reset. After release, one fresh 5-cycle pulse on ch0 starts `SYNC_STAGES` edges after release.
- **Mode switch during pulse:** mode 00, pulse active with PULSE_W=6, switch to 11 mid-pulse → the pulse completes its full 6 cycles, and a subsequent rise produces no pulse.
